// File: rtl/multi_core_pkg.sv
// Shared run-state encoding and default widths for the multi-core array and its data memory.
package multi_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_REG_WIDTH  = 12;
  localparam int DEF_CORE_COUNT = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/data_bank.sv
// Single-port, read-first RAM with one-cycle registered read data.
module data_bank #(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic [REG_WIDTH-1:0]  rdata
);

  logic [REG_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [REG_WIDTH-1:0] rdata_d;
  logic [REG_WIDTH-1:0] rdata_q;

  // Read path samples the array before this edge's write lands.
  always_comb begin
    rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/multi_core_data_mem.sv
// Per-core data banks, host preload/readback port and run controller for the core array.
// Optional RUN_TIMEOUT_EN adds a TIMEOUT parameter and a timedOut flag that forces DONE.
module multi_core_data_mem
  import multi_core_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int CORE_COUNT = DEF_CORE_COUNT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`ifdef RUN_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 4096
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH*CORE_COUNT-1:0] dataMemAddr,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]  processorDataOut,
  input  logic [CORE_COUNT-1:0]            DataMemWrEn,
  output logic [REG_WIDTH*CORE_COUNT-1:0]  ProcessorDataIn,
  input  logic [CORE_COUNT-1:0]            core_done,
  output logic                             processStart,
  input  logic                             hostStart,
  input  logic                             hostClear,
  input  logic [$clog2(CORE_COUNT)-1:0]    hostSel,
  input  logic [ADDR_WIDTH-1:0]            hostAddr,
  input  logic                             hostWrEn,
  input  logic [REG_WIDTH-1:0]             hostWrData,
  output logic [REG_WIDTH-1:0]             hostRdData,
  output logic                             hostErr,
  output logic                             allDone,
  output logic [CNT_WIDTH-1:0]             runCycles,
`ifdef RUN_TIMEOUT_EN
  output logic                             timedOut,
`endif
  output logic [1:0]                       dbg_state
);

  localparam int SEL_W = $clog2(CORE_COUNT);

  state_e                 state_d, state_q;
  logic [CORE_COUNT-1:0]  sticky_d, sticky_q;
  logic [CNT_WIDTH-1:0]   run_cycles_d, run_cycles_q;
  logic                   process_start_d, process_start_q;
  logic                   all_done_d, all_done_q;
  logic                   host_err_d, host_err_q;
  logic                   timed_out_d, timed_out_q;
  logic                   host_rd_vld_d, host_rd_vld_q;
  logic [SEL_W-1:0]       host_sel_d, host_sel_q;
  logic                   launch;
  logic                   host_sel_ok;

  logic [ADDR_WIDTH-1:0]  bank_addr  [CORE_COUNT];
  logic [REG_WIDTH-1:0]   bank_wdata [CORE_COUNT];
  logic [REG_WIDTH-1:0]   bank_rdata [CORE_COUNT];
  logic [CORE_COUNT-1:0]  bank_we;

  assign host_sel_ok = (int'(hostSel) < CORE_COUNT);

  // Run controller: all flops share one next-state computation.
  always_comb begin
    state_d         = state_q;
    sticky_d        = sticky_q;
    run_cycles_d    = run_cycles_q;
    timed_out_d     = timed_out_q;
    process_start_d = 1'b0;
    host_err_d      = 1'b0;
    launch          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hostStart) launch = 1'b1;
      end
      ST_RUN: begin
        host_err_d = hostWrEn;
        sticky_d   = sticky_q | core_done;
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + CNT_WIDTH'(1);
        if (&sticky_d) state_d = ST_DONE;
`ifdef RUN_TIMEOUT_EN
        if (run_cycles_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (hostStart)      launch  = 1'b1;
        else if (hostClear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (launch) begin
      state_d         = ST_RUN;
      process_start_d = 1'b1;
      sticky_d        = '0;
      run_cycles_d    = '0;
      timed_out_d     = 1'b0;
    end
    all_done_d    = (state_d == ST_DONE);
    host_rd_vld_d = (state_q != ST_RUN) && host_sel_ok;
    host_sel_d    = hostSel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      sticky_q        <= '0;
      run_cycles_q    <= '0;
      process_start_q <= 1'b0;
      all_done_q      <= 1'b0;
      host_err_q      <= 1'b0;
      timed_out_q     <= 1'b0;
      host_rd_vld_q   <= 1'b0;
      host_sel_q      <= '0;
    end else begin
      state_q         <= state_d;
      sticky_q        <= sticky_d;
      run_cycles_q    <= run_cycles_d;
      process_start_q <= process_start_d;
      all_done_q      <= all_done_d;
      host_err_q      <= host_err_d;
      timed_out_q     <= timed_out_d;
      host_rd_vld_q   <= host_rd_vld_d;
      host_sel_q      <= host_sel_d;
    end
  end

  // Bank port mux: cores own their bank in RUN, the host owns bank hostSel otherwise.
  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      bank_addr[i]  = dataMemAddr[ADDR_WIDTH*i +: ADDR_WIDTH];
      bank_wdata[i] = processorDataOut[REG_WIDTH*i +: REG_WIDTH];
      bank_we[i]    = 1'b0;
      if (state_q == ST_RUN) begin
        bank_we[i] = DataMemWrEn[i];
      end else if (host_sel_ok && (int'(hostSel) == i)) begin
        bank_addr[i]  = hostAddr;
        bank_wdata[i] = hostWrData;
        bank_we[i]    = hostWrEn;
      end
    end
    if (rst) bank_we = '0;
  end

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_bank
    data_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .REG_WIDTH (REG_WIDTH)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (bank_we[g]),
      .addr (bank_addr[g]),
      .wdata(bank_wdata[g]),
      .rdata(bank_rdata[g])
    );
    assign ProcessorDataIn[REG_WIDTH*g +: REG_WIDTH] = bank_rdata[g];
  end

  assign hostRdData   = host_rd_vld_q ? bank_rdata[host_sel_q] : '0;
  assign processStart = process_start_q;
  assign hostErr      = host_err_q;
  assign allDone      = all_done_q;
  assign runCycles    = run_cycles_q;
  assign dbg_state    = state_q;
`ifdef RUN_TIMEOUT_EN
  assign timedOut     = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout = timed_out_q;
`endif

endmodule

// File: tb/tb_multi_core_data_mem.sv
// Directed bench for multi_core_data_mem: host preload/readback, run sequencing, core access, mid-run reset.
module tb_multi_core_data_mem;

  logic        clk;
  logic        rst;
  logic [31:0] dataMemAddr;
  logic [47:0] processorDataOut;
  logic [3:0]  DataMemWrEn;
  logic [47:0] ProcessorDataIn;
  logic [3:0]  core_done;
  logic        processStart;
  logic        hostStart;
  logic        hostClear;
  logic [1:0]  hostSel;
  logic [7:0]  hostAddr;
  logic        hostWrEn;
  logic [11:0] hostWrData;
  logic [11:0] hostRdData;
  logic        hostErr;
  logic        allDone;
  logic [15:0] runCycles;
  logic [1:0]  dbg_state;
`ifdef RUN_TIMEOUT_EN
  logic        timedOut;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  multi_core_data_mem #(
    .REG_WIDTH (12),
    .CORE_COUNT(4),
    .ADDR_WIDTH(8),
    .CNT_WIDTH (16)
`ifdef RUN_TIMEOUT_EN
    ,
    .TIMEOUT   (16)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dataMemAddr     (dataMemAddr),
    .processorDataOut(processorDataOut),
    .DataMemWrEn     (DataMemWrEn),
    .ProcessorDataIn (ProcessorDataIn),
    .core_done       (core_done),
    .processStart    (processStart),
    .hostStart       (hostStart),
    .hostClear       (hostClear),
    .hostSel         (hostSel),
    .hostAddr        (hostAddr),
    .hostWrEn        (hostWrEn),
    .hostWrData      (hostWrData),
    .hostRdData      (hostRdData),
    .hostErr         (hostErr),
    .allDone         (allDone),
    .runCycles       (runCycles),
`ifdef RUN_TIMEOUT_EN
    .timedOut        (timedOut),
`endif
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [7:0] addr, input logic [11:0] data);
    hostSel    = sel;
    hostAddr   = addr;
    hostWrData = data;
    hostWrEn   = 1'b1;
    tick();
    hostWrEn   = 1'b0;
  endtask

  task automatic host_read_chk(input string tag, input logic [1:0] sel, input logic [7:0] addr,
                               input logic [11:0] exp);
    hostSel  = sel;
    hostAddr = addr;
    hostWrEn = 1'b0;
    tick();
    chk(tag, 48'(hostRdData), 48'(exp));
  endtask

  initial begin
    rst              = 1'b1;
    dataMemAddr      = '0;
    processorDataOut = '0;
    DataMemWrEn      = '0;
    core_done        = '0;
    hostStart        = 1'b0;
    hostClear        = 1'b0;
    hostSel          = '0;
    hostAddr         = '0;
    hostWrEn         = 1'b0;
    hostWrData       = '0;
    tick();
    tick();

    chk("rst_processStart", 48'(processStart), 48'd0);
    chk("rst_allDone", 48'(allDone), 48'd0);
    chk("rst_runCycles", 48'(runCycles), 48'd0);
    chk("rst_hostErr", 48'(hostErr), 48'd0);
    chk("rst_hostRdData", 48'(hostRdData), 48'd0);
    chk("rst_ProcessorDataIn", ProcessorDataIn, 48'd0);
    chk("rst_state", 48'(dbg_state), 48'(S_IDLE));
    rst = 1'b0;

    // Host preload in IDLE
    host_write(2'd0, 8'h10, 12'h100);
    host_write(2'd1, 8'h10, 12'h101);
    host_write(2'd2, 8'h10, 12'h102);
    host_write(2'd3, 8'h10, 12'h103);
    host_write(2'd2, 8'h10, 12'h0A5);
    host_write(2'd1, 8'h03, 12'h111);
    host_write(2'd3, 8'h20, 12'h222);

    host_read_chk("host_rd_b2", 2'd2, 8'h10, 12'h0A5);
    host_read_chk("host_rd_b0", 2'd0, 8'h10, 12'h100);
    host_read_chk("host_rd_b1", 2'd1, 8'h10, 12'h101);
    host_read_chk("host_rd_b3", 2'd3, 8'h10, 12'h103);

    // Host read-first: same-cycle write returns the old word
    hostSel = 2'd0; hostAddr = 8'h10; hostWrData = 12'h3C3; hostWrEn = 1'b1;
    tick();
    hostWrEn = 1'b0;
    chk("host_rd_first", 48'(hostRdData), 48'h100);
    host_read_chk("host_rd_new", 2'd0, 8'h10, 12'h3C3);

    // Core lanes still read in IDLE, but core writes are ignored
    hostSel          = 2'd2;
    dataMemAddr      = 32'h0000_1000;
    processorDataOut = 48'h0000_00EE_E000;
    DataMemWrEn      = 4'b0010;
    tick();
    DataMemWrEn = 4'b0000;
    chk("idle_lane1_rd", 48'(ProcessorDataIn[23:12]), 48'h101);
    tick();
    chk("idle_lane1_nowr", 48'(ProcessorDataIn[23:12]), 48'h101);

    // core_done outside RUN must not pre-load the sticky bits
    core_done = 4'hF;
    tick();
    core_done = 4'h0;
    chk("idle_done_ignored", 48'(dbg_state), 48'(S_IDLE));
    dataMemAddr = '0;

    // Run: done pulses at cycles 3,5,9,4 (cycle 0 carries processStart)
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("run_ps_c%0d", c), 48'(processStart), 48'(c == 0));
      chk($sformatf("run_cyc_c%0d", c), 48'(runCycles), 48'(c));
      chk($sformatf("run_alldone_c%0d", c), 48'(allDone), 48'd0);
      chk($sformatf("run_state_c%0d", c), 48'(dbg_state), 48'(S_RUN));
      if (c == 2) chk("run_lane1_old", 48'(ProcessorDataIn[23:12]), 48'h111);
      if (c == 3) begin
        chk("run_lane1_new", 48'(ProcessorDataIn[23:12]), 48'h7FF);
        chk("run_hostErr_pulse", 48'(hostErr), 48'd1);
        chk("run_hostRd_zero", 48'(hostRdData), 48'd0);
      end
      if (c == 4) chk("run_hostErr_clear", 48'(hostErr), 48'd0);
      core_done = {c == 4, c == 9, c == 5, c == 3};
      if (c == 1) begin
        dataMemAddr      = 32'h0000_0300;
        processorDataOut = 48'h0000_007F_F000;
        DataMemWrEn      = 4'b0010;
      end else begin
        DataMemWrEn = 4'b0000;
      end
      if (c == 2) begin
        hostSel = 2'd3; hostAddr = 8'h20; hostWrData = 12'h555; hostWrEn = 1'b1;
      end else begin
        hostWrEn = 1'b0;
      end
      tick();
    end
    core_done = 4'h0;
    chk("done_allDone", 48'(allDone), 48'd1);
    chk("done_runCycles", 48'(runCycles), 48'd10);
    chk("done_state", 48'(dbg_state), 48'(S_DONE));
    chk("done_ps_low", 48'(processStart), 48'd0);

    host_read_chk("done_host_rd_b3", 2'd3, 8'h20, 12'h222);
    chk("done_runCycles_held", 48'(runCycles), 48'd10);
    chk("done_allDone_held", 48'(allDone), 48'd1);

    // Core write in DONE is ignored
    dataMemAddr      = 32'h0000_0300;
    processorDataOut = 48'h0;
    DataMemWrEn      = 4'b0010;
    tick();
    DataMemWrEn = 4'b0000;
    host_read_chk("done_core_wr_ignored", 2'd1, 8'h03, 12'h7FF);

    hostClear = 1'b1;
    tick();
    hostClear = 1'b0;
    chk("clear_state", 48'(dbg_state), 48'(S_IDLE));
    chk("clear_allDone", 48'(allDone), 48'd0);
    chk("clear_runCycles_held", 48'(runCycles), 48'd10);

    // Reset in the middle of a run with two cores done
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    core_done = 4'b0011;
    tick();
    core_done = 4'b0000;
    chk("mid_runCycles", 48'(runCycles), 48'd1);
    chk("mid_state", 48'(dbg_state), 48'(S_RUN));
    rst              = 1'b1;
    dataMemAddr      = 32'h0000_0010;
    processorDataOut = 48'h0000_0000_0FFF;
    DataMemWrEn      = 4'b0001;
    tick();
    rst         = 1'b0;
    DataMemWrEn = 4'b0000;
    dataMemAddr = '0;
    chk("mrst_state", 48'(dbg_state), 48'(S_IDLE));
    chk("mrst_allDone", 48'(allDone), 48'd0);
    chk("mrst_runCycles", 48'(runCycles), 48'd0);
    chk("mrst_ps", 48'(processStart), 48'd0);
    host_read_chk("mrst_b0_kept", 2'd0, 8'h10, 12'h3C3);
    host_read_chk("mrst_b2_kept", 2'd2, 8'h10, 12'h0A5);

    // All cores done on the processStart cycle, then hostStart beats hostClear
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    core_done = 4'hF;
    tick();
    core_done = 4'h0;
    chk("fast_allDone", 48'(allDone), 48'd1);
    chk("fast_runCycles", 48'(runCycles), 48'd1);
    hostStart = 1'b1;
    hostClear = 1'b1;
    tick();
    hostStart = 1'b0;
    hostClear = 1'b0;
    chk("prio_state", 48'(dbg_state), 48'(S_RUN));
    chk("prio_ps", 48'(processStart), 48'd1);
    chk("prio_runCycles", 48'(runCycles), 48'd0);
    chk("prio_allDone", 48'(allDone), 48'd0);
    core_done = 4'hF;
    tick();
    core_done = 4'h0;
    chk("prio_done", 48'(dbg_state), 48'(S_DONE));

`ifdef RUN_TIMEOUT_EN
    // Core 3 never finishes: timeout forces DONE
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    core_done = 4'b0111;
    tick();
    core_done = 4'b0000;
    repeat (14) tick();
    chk("to_c15_state", 48'(dbg_state), 48'(S_RUN));
    chk("to_c15_flag", 48'(timedOut), 48'd0);
    tick();
    chk("to_state", 48'(dbg_state), 48'(S_DONE));
    chk("to_runCycles", 48'(runCycles), 48'd16);
    chk("to_flag", 48'(timedOut), 48'd1);
    hostStart = 1'b1;
    tick();
    hostStart = 1'b0;
    chk("to_flag_cleared", 48'(timedOut), 48'd0);
    chk("to_restart_ps", 48'(processStart), 48'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_core_data_mem.md
Name: multi_core_data_mem

Overview:
- Memory-side responder and run controller for the multi-core processor array.
- Serves each core's data-memory port from a private bank: read data returned, writes accepted.
- Issues the shared processStart pulse and aggregates per-core done into one completion flag.
- Gives a host port to preload operands and read back results while the cores are idle.

Parameters:
- REG_WIDTH, 12, data word width per core.
- CORE_COUNT, 4, number of cores and banks.
- ADDR_WIDTH, 8, per-core data address width; bank depth 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the run-cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- dataMemAddr  in  ADDR_WIDTH*CORE_COUNT  per-core address, lane i at [ADDR_WIDTH*i +: ADDR_WIDTH].
- processorDataOut  in  REG_WIDTH*CORE_COUNT  per-core write data.
- DataMemWrEn  in  CORE_COUNT  per-core write enable.
- ProcessorDataIn  out  REG_WIDTH*CORE_COUNT  per-core read data (registered).
- core_done  in  CORE_COUNT  per-core done, level or pulse.
- processStart  out  1  one-cycle start pulse to all cores.
- hostStart  in  1  launch a run.
- hostClear  in  1  return from DONE to IDLE.
- hostSel  in  $clog2(CORE_COUNT)  bank select for host access.
- hostAddr  in  ADDR_WIDTH  host address.
- hostWrEn  in  1  host write.
- hostWrData  in  REG_WIDTH  host write data.
- hostRdData  out  REG_WIDTH  host read data (registered).
- hostErr  out  1  one-cycle pulse: host write dropped during RUN.
- allDone  out  1  level; high in DONE.
- runCycles  out  CNT_WIDTH  cycles spent in the last or current run.

Behaviour:
- Reset values: all outputs 0, state IDLE, sticky done bits 0. Bank contents are not cleared.
- States:
  - IDLE: hostStart -> RUN.
  - RUN: all sticky done bits set -> DONE.
  - DONE: hostStart -> RUN; else hostClear -> IDLE. hostStart wins if both are high.
- Entry to RUN: processStart=1 for exactly the first RUN cycle; sticky bits cleared; runCycles cleared to 0.
- runCycles: increments each RUN cycle, saturates at all-ones, held in IDLE/DONE.
- Sticky done: bit i sets when core_done[i]=1 in any RUN cycle, including the processStart cycle. Inputs are ignored outside RUN. Transition to DONE occurs the cycle after the last bit sets.
- allDone: registered, high exactly while in DONE.
- Bank ownership in RUN: lane i owns bank i.
  - Write on DataMemWrEn[i].
  - ProcessorDataIn lane i = bank[i][addr] one cycle after address presentation.
  - Same-cycle read/write to same address returns old data (read-first).
- Bank ownership in IDLE/DONE: host owns bank hostSel.
  - Core writes ignored; ProcessorDataIn lanes still return reads.
  - hostRdData = bank[hostSel][hostAddr] one cycle later, read-first.
- Host access in RUN: hostWrEn dropped and hostErr pulses one cycle; hostRdData holds 0.
- hostSel >= CORE_COUNT: write ignored, read returns 0.
- Reset mid-RUN: immediate return to IDLE next edge; no processStart; in-flight writes on that edge are discarded.

Optional Feature:
- Macro RUN_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 4096) and output timedOut (1 bit).
  - In RUN, runCycles reaching TIMEOUT-1 forces DONE next cycle with timedOut=1.
  - timedOut clears on next entry to RUN or on rst.
- When undefined: no timeout; RUN persists until all done; no timedOut port.

Decomposition:
- Package multi_core_pkg: state enum (IDLE, RUN, DONE) and default width constants shared with the processor top.
- One sub-module, data_bank: single-port, read-first, one-cycle-latency RAM of 2**ADDR_WIDTH x REG_WIDTH, instantiated CORE_COUNT times in a generate loop with a per-bank port mux.

Test Plan:
- Host writes 12'h0A5 to bank 2 addr 8'h10 in IDLE, reads back -> hostRdData=12'h0A5 one cycle after read; other banks at 8'h10 unchanged.
- hostStart in IDLE -> processStart high exactly one cycle; core_done pulses at cycles 3,5,9,4 -> allDone rises cycle 10, runCycles=10.
- In RUN, core 1 writes 12'h7FF to addr 8'h03, reads same addr next cycle -> lane 1 returns 12'h7FF; same-cycle read returned old value.
- Host write during RUN -> hostErr one-cycle pulse; after DONE, host read of that address shows the unmodified prior value.
- rst asserted mid-RUN with two cores done -> next cycle state IDLE, allDone=0, runCycles=0, bank data preserved.
- RUN_TIMEOUT_EN, TIMEOUT=16, core 3 never done -> DONE at runCycles=15+1 with timedOut=1; hostStart clears timedOut.
